// File: rtl/msrv32_immediate_adder.sv
// Immediate adder: base (pc or rs1) + immediate, with a combinational lookahead sum and a
// registered target address. Define IADDER_MISALIGN_CHK_EN to register the target-misaligned flag.
module msrv32_immediate_adder #(
  parameter int XLEN = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs_1_in,
  input  logic            i_adder_src_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            stall_in,
  output logic [XLEN-1:0] i_adder_out,
  output logic [XLEN-1:0] i_adder_sum_comb_out,
  output logic            misaligned_out
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] target_q;

  assign base = i_adder_src_in ? rs_1_in : pc_in;
  assign sum  = base + imm_in;

  assign i_adder_sum_comb_out = sum;

  // JALR clears bit 0 of the computed target; pc-relative targets pass through untouched.
  assign target_d = i_adder_src_in ? {sum[XLEN-1:1], 1'b0} : sum;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      target_q <= '0;
    end else if (!stall_in) begin
      target_q <= target_d;
    end
  end

  assign i_adder_out = target_q;

`ifdef IADDER_MISALIGN_CHK_EN
  logic misaligned_d;
  logic misaligned_q;

  assign misaligned_d = target_d[1];

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      misaligned_q <= 1'b0;
    end else if (!stall_in) begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned_out = misaligned_q;
`else
  assign misaligned_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_immediate_adder.sv
// Directed bench for msrv32_immediate_adder: expected targets queued at drive time,
// popped and compared one edge later.
module tb_msrv32_immediate_adder;

`ifdef IADDER_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] imm = '0;
  logic        src = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] i_adder_out;
  logic [31:0] sum_comb;
  logic        misaligned;

  msrv32_immediate_adder #(.XLEN(32)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .pc_in                  (pc),
    .rs_1_in                (rs1),
    .i_adder_src_in         (src),
    .imm_in                 (imm),
    .stall_in               (stall),
    .i_adder_out            (i_adder_out),
    .i_adder_sum_comb_out   (sum_comb),
    .misaligned_out         (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_addr = '0;
  logic        m_mis = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum(input logic s, input logic [31:0] p,
                                          input logic [31:0] r, input logic [31:0] i);
    return (s ? r : p) + i;
  endfunction

  task automatic apply(input string tag, input logic s, input logic [31:0] p,
                       input logic [31:0] r, input logic [31:0] i, input logic st);
    logic [31:0] raw;
    exp_t        e;
    @(negedge clk);
    src = s; pc = p; rs1 = r; imm = i; stall = st;
    raw = ref_sum(s, p, r, i);
    #1;
    chk32({tag, "_comb"}, sum_comb, raw);
    if (!st) begin
      m_addr = s ? (raw & 32'hFFFF_FFFE) : raw;
      m_mis  = MIS_EN ? m_addr[1] : 1'b0;
    end
    sb.push_back('{m_addr, m_mis});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk32(tag, i_adder_out, e.addr);
    chk1({tag, "_mis"}, misaligned, e.mis);
  endtask

  initial begin
    // reset held low with random activity
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      src = 1'($urandom); pc = $urandom; rs1 = $urandom; imm = $urandom; stall = 1'($urandom);
      @(posedge clk);
      #1;
      chk32("rst_out", i_adder_out, 32'h0);
      chk1("rst_mis", misaligned, 1'b0);
      chk32("rst_comb", sum_comb, ref_sum(src, pc, rs1, imm));
    end
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;

    apply("jalr_5p2", 1'b1, 32'h0, 32'h5, 32'h2, 1'b0);
    apply("pcrel_0p2", 1'b0, 32'h0, 32'h0, 32'h2, 1'b0);
    apply("wrap", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0);
    apply("neg_imm", 1'b0, 32'h100, 32'h0, 32'hFFFF_FFF0, 1'b0);

    apply("stall_load", 1'b1, 32'h0, 32'h5, 32'h2, 1'b0);
    for (int k = 0; k < 3; k++)
      apply("stall_hold", 1'($urandom), $urandom, $urandom, $urandom, 1'b1);
    apply("stall_release", 1'b0, 32'h40, 32'h0, 32'h13, 1'b0);

    apply("sel_rs1", 1'b1, 32'h1000, 32'h4, 32'h2, 1'b0);
    apply("sel_pc", 1'b0, 32'h1000, 32'h4, 32'h2, 1'b0);
    apply("jalr_odd", 1'b1, 32'h0, 32'h3, 32'h0, 1'b0);
    apply("pc_odd", 1'b0, 32'h7, 32'h0, 32'h0, 1'b0);

    for (int k = 0; k < 20; k++)
      apply("random", 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) == 0));

    // load a nonzero target, then reset asynchronously mid-cycle while stalled
    apply("pre_async", 1'b0, 32'h1234_5678, 32'h0, 32'h2, 1'b0);
    @(negedge clk);
    #2;
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk32("async_out", i_adder_out, 32'h0);
    chk1("async_mis", misaligned, 1'b0);
    chk32("async_comb", sum_comb, ref_sum(src, pc, rs1, imm));
    @(posedge clk);
    #1;
    chk32("async_hold", i_adder_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = '0;
    m_mis  = 1'b0;
    apply("post_rst", 1'b0, 32'h2000, 32'h0, 32'h6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
